// File: rtl/approx_adder_if.sv
// approx_adder_if: valid/ready request and response bundle for approx_adder_pipe.
// The master drives operands and out_ready; the slave returns results and in_ready.
interface approx_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_mode, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_mode, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_err
    );
endinterface

// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe: pipelined approximate adder with a shadow exact chain.
// The low APPROX_BITS positions use the OR-based approximate cell when mode=1.
// The carry chain is cut into STAGES segments of SEG bits each. Every stage
// carries two WIDTH-bit vectors: x holds the approximate partial sum in the
// bits already computed and operand A in the bits not yet consumed; y does the
// same for the exact partial sum and operand B. All register bits therefore
// stay live, and the final stage holds both full sums for the error compare.
module approx_adder_pipe #(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 8,
    parameter int STAGES      = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    approx_adder_if.slave bus,
    input  logic          clr_cnt,
    output logic [15:0]   err_cnt
);
    localparam int SEG = WIDTH / STAGES;

    logic                         en;
    logic                         out_err_w;
    logic [STAGES-1:0]            vld_reg;
    logic [STAGES-1:0]            mode_reg;
    logic [STAGES-1:0]            ca_reg;
    logic [STAGES-1:0]            ce_reg;
    logic [STAGES-1:0][WIDTH-1:0] x_reg;
    logic [STAGES-1:0][WIDTH-1:0] y_reg;
    logic [15:0]                  err_cnt_reg;

    // Lockstep advance: the whole pipe moves unless the output is held.
    assign en           = !vld_reg[STAGES-1] || bus.out_ready;
    assign bus.in_ready = en;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] x_in, y_in, x_next, y_next;
            logic             v_in, mode_in, ca_in, ce_in, ca_next, ce_next;

            if (gi == 0) begin : g_head
                assign v_in    = bus.in_valid;
                assign mode_in = bus.in_mode;
                assign ca_in   = bus.in_cin;
                assign ce_in   = bus.in_cin;
                assign x_in    = bus.in_a;
                assign y_in    = bus.in_b;
            end else begin : g_tail
                assign v_in    = vld_reg[gi-1];
                assign mode_in = mode_reg[gi-1];
                assign ca_in   = ca_reg[gi-1];
                assign ce_in   = ce_reg[gi-1];
                assign x_in    = x_reg[gi-1];
                assign y_in    = y_reg[gi-1];
            end

            // Ripple this segment through the approximate and exact chains in parallel.
            always_comb begin
                x_next  = x_in;
                y_next  = y_in;
                ca_next = ca_in;
                ce_next = ce_in;
                for (int k = 0; k < SEG; k++) begin
                    y_next[gi*SEG+k] = x_in[gi*SEG+k] ^ y_in[gi*SEG+k] ^ ce_next;
                    ce_next = (x_in[gi*SEG+k] & y_in[gi*SEG+k]) |
                              (ce_next & (x_in[gi*SEG+k] ^ y_in[gi*SEG+k]));
                    if (mode_in && (gi*SEG + k < APPROX_BITS)) begin
                        x_next[gi*SEG+k] = (x_in[gi*SEG+k] | y_in[gi*SEG+k]) ^ ca_next;
                        ca_next = (x_in[gi*SEG+k] | y_in[gi*SEG+k]) & ca_next;
                    end else begin
                        x_next[gi*SEG+k] = x_in[gi*SEG+k] ^ y_in[gi*SEG+k] ^ ca_next;
                        ca_next = (x_in[gi*SEG+k] & y_in[gi*SEG+k]) |
                                  (ca_next & (x_in[gi*SEG+k] ^ y_in[gi*SEG+k]));
                    end
                end
            end

            // Stage register: loads only on a global advance; reset drops in-flight work.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_reg[gi]  <= 1'b0;
                    mode_reg[gi] <= 1'b0;
                    ca_reg[gi]   <= 1'b0;
                    ce_reg[gi]   <= 1'b0;
                    x_reg[gi]    <= '0;
                    y_reg[gi]    <= '0;
                end else if (en) begin
                    vld_reg[gi]  <= v_in;
                    mode_reg[gi] <= mode_in;
                    ca_reg[gi]   <= ca_next;
                    ce_reg[gi]   <= ce_next;
                    x_reg[gi]    <= x_next;
                    y_reg[gi]    <= y_next;
                end
            end
        end
    endgenerate

    // Exact mode can never disagree with itself, so gate the compare by mode.
    assign out_err_w = mode_reg[STAGES-1] &&
                       ({ca_reg[STAGES-1], x_reg[STAGES-1]} != {ce_reg[STAGES-1], y_reg[STAGES-1]});

    assign bus.out_valid = vld_reg[STAGES-1];
    assign bus.out_sum   = x_reg[STAGES-1];
    assign bus.out_cout  = ca_reg[STAGES-1];
    assign bus.out_err   = out_err_w;

    // Saturating error counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (clr_cnt) begin
            err_cnt_reg <= '0;
        end else if (vld_reg[STAGES-1] && bus.out_ready && out_err_w &&
                     (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
endmodule

// File: tb/tb_approx_adder_pipe.sv
// tb_approx_adder_pipe: scoreboard bench for approx_adder_pipe.
// Main instance (16/8/2) plus two shadow instances (STAGES=1/APPROX_BITS=0 and
// STAGES=4/APPROX_BITS=16) fed with every transaction the main one accepts.
module tb_approx_adder_pipe;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        mode;
        logic [15:0] sum;
        logic        cout;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [15:0] err_cnt, err_cnt_1, err_cnt_4;
    logic [15:0] exp_cnt = '0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_txn = 0;
    logic        chk_lat = 1'b0;
    logic        verbose = 1'b1;
    exp_t        q_m[$], q_1[$], q_4[$];

    approx_adder_if #(.WIDTH(16)) bus ();
    approx_adder_if #(.WIDTH(16)) bus1 ();
    approx_adder_if #(.WIDTH(16)) bus4 ();

    approx_adder_pipe #(.WIDTH(16), .APPROX_BITS(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr_cnt(clr_cnt), .err_cnt(err_cnt)
    );
    approx_adder_pipe #(.WIDTH(16), .APPROX_BITS(0), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .clr_cnt(clr_cnt), .err_cnt(err_cnt_1)
    );
    approx_adder_pipe #(.WIDTH(16), .APPROX_BITS(16), .STAGES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .clr_cnt(clr_cnt), .err_cnt(err_cnt_4)
    );

    // Shadow instances see exactly the transfers of the main instance and never stall.
    assign bus1.in_valid  = bus.in_valid & bus.in_ready;
    assign bus1.in_a      = bus.in_a;
    assign bus1.in_b      = bus.in_b;
    assign bus1.in_cin    = bus.in_cin;
    assign bus1.in_mode   = bus.in_mode;
    assign bus1.out_ready = 1'b1;
    assign bus4.in_valid  = bus.in_valid & bus.in_ready;
    assign bus4.in_a      = bus.in_a;
    assign bus4.in_b      = bus.in_b;
    assign bus4.in_cin    = bus.in_cin;
    assign bus4.in_mode   = bus.in_mode;
    assign bus4.out_ready = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: approximate low bits cell by cell, everything else as plain addition.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                   input logic mode, input int abits, input int cyc_now);
        exp_t        e;
        int          k;
        logic        c;
        logic [15:0] lo;
        logic [16:0] hmask, s17, ex17;
        k  = mode ? abits : 0;
        c  = cin;
        lo = '0;
        for (int i = 0; i < k; i++) begin
            lo[i] = (a[i] | b[i]) ^ c;
            c     = (a[i] | b[i]) & c;
        end
        hmask  = 17'h0FFFF & ~((17'h1 << k) - 17'h1);
        s17    = ({1'b0, a} & hmask) + ({1'b0, b} & hmask) + ({16'h0, c} << k);
        ex17   = {1'b0, a} + {1'b0, b} + {16'h0, cin};
        e.a    = a;
        e.b    = b;
        e.cin  = cin;
        e.mode = mode;
        e.sum  = s17[15:0] | lo;
        e.cout = s17[16];
        e.err  = ({e.cout, e.sum} != ex17);
        e.cyc  = cyc_now;
        return e;
    endfunction

    // Monitor: pop/compare on output transfers, push on input transfers, track err_cnt.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q_m.delete();
            q_1.delete();
            q_4.delete();
            exp_cnt = '0;
            check_eq("rst_out_valid", bus.out_valid, 0);
            check_eq("rst_err_cnt", err_cnt, 0);
        end else begin
            check_eq("err_cnt", err_cnt, exp_cnt);
            if (bus.out_valid && bus.out_ready) begin
                if (q_m.size() == 0) begin
                    check_eq("main_unexpected_out", bus.out_valid, 0);
                end else begin
                    e = q_m.pop_front();
                    n_txn++;
                    if (verbose)
                        $display("txn %0d a=%h b=%h cin=%0d mode=%0d sum=%h cout=%0d err=%0d cnt=%h",
                                 n_txn, e.a, e.b, e.cin, e.mode, bus.out_sum, bus.out_cout,
                                 bus.out_err, err_cnt);
                    check_eq("main_sum", bus.out_sum, e.sum);
                    check_eq("main_cout", bus.out_cout, e.cout);
                    check_eq("main_err", bus.out_err, e.err);
                    if (chk_lat) check_eq("main_latency", cyc - e.cyc, 2);
                    if (!clr_cnt && e.err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                end
            end
            if (clr_cnt) exp_cnt = '0;
            if (bus1.out_valid) begin
                if (q_1.size() == 0) begin
                    check_eq("s1_unexpected_out", bus1.out_valid, 0);
                end else begin
                    e = q_1.pop_front();
                    check_eq("s1_sum", bus1.out_sum, e.sum);
                    check_eq("s1_cout", bus1.out_cout, e.cout);
                    check_eq("s1_err_zero", bus1.out_err, 0);
                    check_eq("s1_latency", cyc - e.cyc, 1);
                end
            end
            if (bus4.out_valid) begin
                if (q_4.size() == 0) begin
                    check_eq("s4_unexpected_out", bus4.out_valid, 0);
                end else begin
                    e = q_4.pop_front();
                    check_eq("s4_sum", bus4.out_sum, e.sum);
                    check_eq("s4_cout", bus4.out_cout, e.cout);
                    check_eq("s4_err", bus4.out_err, e.err);
                    check_eq("s4_latency", cyc - e.cyc, 4);
                    if (e.mode && !e.cin) begin
                        check_eq("s4_or_sum", bus4.out_sum, e.a | e.b);
                        check_eq("s4_or_cout", bus4.out_cout, 0);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q_m.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_mode, 8, cyc));
                q_1.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_mode, 0, cyc));
                q_4.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_mode, 16, cyc));
            end
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic mode);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_mode  = mode;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) check_eq("drive_timeout", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) check_eq("wait_valid_timeout", bus.out_valid, 1);
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic mode,
                            input logic [15:0] es, input logic ec, input logic ee);
        drive(a, b, cin, mode);
        wait_valid();
        check_eq({tag, "_sum"}, bus.out_sum, es);
        check_eq({tag, "_cout"}, bus.out_cout, ec);
        check_eq({tag, "_err"}, bus.out_err, ee);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ra[8], rb[8];
        logic        rc[8], rm[8];
        logic [15:0] hs;
        logic        hc, he, acc;
        int          idx, it;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
            rc[i] = 1'($urandom_range(1, 0));
            rm[i] = 1'($urandom_range(1, 0));
        end

        // Reset values
        @(negedge clk);
        check_eq("reset_sum", bus.out_sum, 0);
        check_eq("reset_cout", bus.out_cout, 0);
        check_eq("reset_err", bus.out_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Directed vectors with latency checking on an idle pipe
        chk_lat = 1'b1;
        directed("approx_basic", 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1);
        check_eq("cnt_after_basic", err_cnt, 1);
        directed("approx_carry", 16'h00FF, 16'h0001, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b1);
        directed("approx_noerr", 16'h0F0F, 16'h00F0, 1'b0, 1'b1, 16'h0FFF, 1'b0, 1'b0);
        directed("exact_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_eq("cnt_after_dir", err_cnt, 2);
        chk_lat = 1'b0;

        // Back-to-back random stream with a 3-cycle output stall
        idx = 0;
        it  = 0;
        while (idx < 8 && it < 60) begin
            bus.out_ready = !(it >= 4 && it <= 6);
            bus.in_valid  = 1'b1;
            bus.in_a      = ra[idx];
            bus.in_b      = rb[idx];
            bus.in_cin    = rc[idx];
            bus.in_mode   = rm[idx];
            @(negedge clk);
            if (it >= 4 && it <= 6) begin
                check_eq("stall_in_ready", bus.in_ready, 0);
                check_eq("stall_out_valid", bus.out_valid, 1);
                if (it == 4) begin
                    hs = bus.out_sum;
                    hc = bus.out_cout;
                    he = bus.out_err;
                end else begin
                    check_eq("stall_hold_sum", bus.out_sum, hs);
                    check_eq("stall_hold_cout", bus.out_cout, hc);
                    check_eq("stall_hold_err", bus.out_err, he);
                end
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            it++;
        end
        check_eq("stream_all_sent", idx, 8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_eq("stream_drained", q_m.size(), 0);

        // Reset with two transactions in flight
        bus.in_valid = 1'b1;
        bus.in_a = 16'h0003; bus.in_b = 16'h0005; bus.in_cin = 1'b0; bus.in_mode = 1'b1;
        @(posedge clk);
        #1;
        bus.in_a = 16'h1234; bus.in_b = 16'h4321;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", bus.out_valid, 0);
        check_eq("midrst_err_cnt", err_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_eq("post_rst_no_stale", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Clear wins over a simultaneous error transfer
        directed("clr_pre", 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1);
        bus.out_ready = 1'b0;
        drive(16'h0002, 16'h0002, 1'b0, 1'b1);
        wait_valid();
        check_eq("cnt_before_clr", err_cnt, 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        check_eq("clr_wins", err_cnt, 0);
        @(posedge clk);
        #1;

        // Saturation: drive more than 0xFFFF error transfers
        verbose = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a = 16'h0001; bus.in_b = 16'h0001; bus.in_cin = 1'b0; bus.in_mode = 1'b1;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        verbose = 1'b1;
        check_eq("sat_err_cnt", err_cnt, 16'hFFFF);
        check_eq("sat_s4_err_cnt", err_cnt_4, 16'hFFFF);
        check_eq("s1_err_cnt_zero", err_cnt_1, 0);
        check_eq("final_q_main", q_m.size(), 0);
        check_eq("final_q_s1", q_1.size(), 0);
        check_eq("final_q_s4", q_4.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
